dice_display_mux: RTL
=====================

DICE_DISPLAY_MUX -- requirements
Module: dice_display_mux

Interface
REQ-001 Parameter REFRESH_CNT, default 1000: clock cycles each digit is driven before the scan toggles (legal range 2 or more).
REQ-002 Parameter MAX_FACE, default 20: largest legal die face (legal range 1 to 99).
REQ-003 Port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 Port in_valid, input, 1 bit: producer presents a roll result on in_face.
REQ-006 Port in_ready, output, 1 bit: block can accept a result this cycle.
REQ-007 Port in_face, input, 5 bits: unsigned roll result.
REQ-008 Port seg, output, 7 bits: active-low segments, bit order gfedcba.
REQ-009 Port an, output, 2 bits: active-low digit enables; an[1] is tens, an[0] is units.
REQ-010 Port face_q, output, 5 bits: last accepted in_face.
REQ-011 Port err, output, 1 bit: sticky flag for an out-of-range face.

Function
REQ-012 Transfer occurs on a rising clk edge with in_valid=1 and in_ready=1; in_face is sampled into face_q on that edge.
REQ-013 FSM states are IDLE, CONV and SHOW; in_ready=1 in IDLE and SHOW and 0 in CONV.
REQ-014 IDLE: no value held; an=2'b11, seg=7'h7F.
REQ-015 Accepting 1 to MAX_FACE loads remainder=in_face and tens=0, then enters CONV.
REQ-016 Each CONV cycle: if remainder>=10, subtract 10 and increment tens; otherwise latch tens/remainder as display digits and enter SHOW.
REQ-017 CONV duration is tens+1 cycles (7 -> 1, 17 -> 2, 20 -> 3); new digits drive seg from the first SHOW cycle.
REQ-018 While in CONV after an accept from SHOW, the previous digits stay displayed; there is no blank gap.
REQ-019 Accepting in_face=0 or in_face>MAX_FACE sets err, updates face_q, skips CONV and enters SHOW with both digits showing dash 7'h3F.
REQ-020 err stays set until reset; later valid faces display normally while err remains 1.
REQ-021 Scan counter runs 0..REFRESH_CNT-1 in every state, including IDLE and CONV; on wrap, digit select toggles.
REQ-022 In SHOW or CONV with prior digits: select=0 gives an=2'b10 with the units pattern; select=1 gives an=2'b01 with the tens pattern.
REQ-023 Digit patterns: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=18 (hex); blank=7F; dash=3F.
REQ-024 seg and an are registered: both change on the same edge and never glitch between digits.

Reset
REQ-025 Asserting reset forces, immediately and without a clock: state=IDLE, seg=7'h7F, an=2'b11, face_q=0, err=0, scan counter=0, select=0, stored digits=0.
REQ-026 Reset during CONV or SHOW discards the value in progress or held; after release in_ready=1 (IDLE).

Configuration
REQ-027 Macro DICE_LEADING_ZERO_BLANK_EN defined: when tens=0, the tens slot drives an=2'b11 and seg=7'h7F for its full period; scan timing is unchanged.
REQ-028 Macro DICE_LEADING_ZERO_BLANK_EN undefined: tens=0 is shown as 7'h40.

Structure
REQ-029 Package dice_pkg holds the FSM state enum, the SEG_DIGIT[0:9] constant table, SEG_BLANK, SEG_DASH and the default MAX_FACE.
REQ-030 Sub-module seg7_decode maps a 4-bit BCD digit to the 7-bit active-low pattern using dice_pkg; it is instantiated once on the selected digit.

Verification (bench REFRESH_CNT=4, MAX_FACE=20)
REQ-031 Assert reset mid-scan, release, hold in_valid=0 -> seg=7F, an=11, in_ready=1, err=0 indefinitely.
REQ-032 Accept 17 -> in_ready=0 for 2 cycles, then units slot shows seg=78 with an=10, and after 4 cycles tens slot shows seg=79 with an=01.
REQ-033 Accept 7 with macro defined, then undefined -> tens slot an=11/seg=7F, then an=01/seg=40.
REQ-034 Accept 20 while showing 5 -> 3 CONV cycles still show 05, then 20 appears; face_q=20.
REQ-035 Accept 21, then 3 -> err=1 and both slots show 3F; then digits 03 are shown while err stays 1.
REQ-036 Assert reset in the second CONV cycle of 19 -> outputs blank immediately; after release the FSM is in IDLE, face_q=0 and the next accept of 4 shows 04.

Source files
------------

// File: rtl/dice_pkg.sv
// Shared types and constants for the dice display multiplexer.
package dice_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_SHOW = 2'd2
  } state_e;

  // Active-low segment patterns, bit order gfedcba.
  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00, 7'h18
  };

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  localparam int DEFAULT_MAX_FACE = 20;

endpackage

// File: rtl/seg7_decode.sv
// BCD digit to active-low seven-segment pattern; non-BCD codes go blank.
module seg7_decode
  import dice_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  // Table lookup guarded against codes 10..15.
  always_comb begin
    seg = SEG_BLANK;
    if (digit <= 4'd9) begin
      seg = SEG_DIGIT[digit];
    end else begin
      seg = SEG_BLANK;
    end
  end

endmodule

// File: rtl/dice_display_mux.sv
// Two-digit multiplexed display of a die roll with binary-to-BCD conversion.
// Optional macro DICE_LEADING_ZERO_BLANK_EN blanks a zero tens digit.
module dice_display_mux
  import dice_pkg::*;
#(
  parameter int REFRESH_CNT = 1000,
  parameter int MAX_FACE    = DEFAULT_MAX_FACE
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [4:0] in_face,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic [4:0] face_q,
  output logic       err
);

  localparam int CW = (REFRESH_CNT > 2) ? $clog2(REFRESH_CNT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_CNT - 1);

`ifdef DICE_LEADING_ZERO_BLANK_EN
  localparam bit LZ_BLANK = 1'b1;
`else
  localparam bit LZ_BLANK = 1'b0;
`endif

  state_e          state_q, state_d;
  logic [4:0]      rem_q, rem_d;
  logic [3:0]      acc_tens_q, acc_tens_d;
  logic [3:0]      tens_q, tens_d;
  logic [3:0]      units_q, units_d;
  logic            have_q, have_d;
  logic            dash_q, dash_d;
  logic [4:0]      face_d;
  logic            err_q, err_d;
  logic [CW-1:0]   scan_q, scan_d;
  logic            sel_q, sel_d;
  logic [6:0]      seg_q, seg_d;
  logic [1:0]      an_q, an_d;
  logic            face_bad_s;
  logic [3:0]      digit_sel_s;
  logic [6:0]      digit_seg_s;

  assign in_ready   = (state_q != ST_CONV);
  assign face_bad_s = (in_face == 5'd0) || (32'(in_face) > 32'(MAX_FACE));
  assign seg        = seg_q;
  assign an         = an_q;
  assign err        = err_q;

  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    acc_tens_d = acc_tens_q;
    tens_d     = tens_q;
    units_d    = units_q;
    have_d     = have_q;
    dash_d     = dash_q;
    face_d     = face_q;
    err_d      = err_q;
    scan_d     = scan_q;
    sel_d      = sel_q;

    if (scan_q == CNT_LAST) begin
      scan_d = {CW{1'b0}};
      sel_d  = ~sel_q;
    end else begin
      scan_d = scan_q + CW'(1);
      sel_d  = sel_q;
    end

    case (state_q)
      ST_IDLE, ST_SHOW: begin
        if (in_valid) begin
          face_d = in_face;
          if (face_bad_s) begin
            // Out-of-range roll skips conversion and shows dashes at once.
            err_d   = 1'b1;
            dash_d  = 1'b1;
            have_d  = 1'b1;
            state_d = ST_SHOW;
          end else begin
            rem_d      = in_face;
            acc_tens_d = 4'd0;
            state_d    = ST_CONV;
          end
        end else begin
          state_d = state_q;
        end
      end
      ST_CONV: begin
        if (rem_q >= 5'd10) begin
          rem_d      = rem_q - 5'd10;
          acc_tens_d = acc_tens_q + 4'd1;
        end else begin
          tens_d  = acc_tens_q;
          units_d = rem_q[3:0];
          dash_d  = 1'b0;
          have_d  = 1'b1;
          state_d = ST_SHOW;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign digit_sel_s = sel_d ? tens_d : units_d;

  seg7_decode u_seg7_decode (
    .digit (digit_sel_s),
    .seg   (digit_seg_s)
  );

  // Display is computed from next-cycle values so seg/an switch together with the digits.
  always_comb begin
    seg_d = SEG_BLANK;
    an_d  = 2'b11;
    if ((state_d == ST_IDLE) || !have_d) begin
      seg_d = SEG_BLANK;
      an_d  = 2'b11;
    end else if (!sel_d) begin
      seg_d = dash_d ? SEG_DASH : digit_seg_s;
      an_d  = 2'b10;
    end else if (LZ_BLANK && !dash_d && (tens_d == 4'd0)) begin
      seg_d = SEG_BLANK;
      an_d  = 2'b11;
    end else begin
      seg_d = dash_d ? SEG_DASH : digit_seg_s;
      an_d  = 2'b01;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      rem_q      <= 5'd0;
      acc_tens_q <= 4'd0;
      tens_q     <= 4'd0;
      units_q    <= 4'd0;
      have_q     <= 1'b0;
      dash_q     <= 1'b0;
      face_q     <= 5'd0;
      err_q      <= 1'b0;
      scan_q     <= {CW{1'b0}};
      sel_q      <= 1'b0;
      seg_q      <= SEG_BLANK;
      an_q       <= 2'b11;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      acc_tens_q <= acc_tens_d;
      tens_q     <= tens_d;
      units_q    <= units_d;
      have_q     <= have_d;
      dash_q     <= dash_d;
      face_q     <= face_d;
      err_q      <= err_d;
      scan_q     <= scan_d;
      sel_q      <= sel_d;
      seg_q      <= seg_d;
      an_q       <= an_d;
    end
  end

endmodule
